// File: rtl/shift_rows_pipe.sv
// Registered AES ShiftRows / InvShiftRows stage for Nb = 4, 6 or 8 columns,
// with the mode carried per beat and a small output FIFO for backpressure.
module shift_rows_pipe #(
    parameter  int NB    = 4,
    parameter  int DEPTH = 2,
    localparam int W     = 32 * NB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:W-1] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:W-1] out_state
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("shift_rows_pipe: DEPTH must be a power of two >= 2");
        end
    endgenerate

    // Rijndael row offsets; the 8-column block uses 0,1,3,4.
    function automatic int row_off(input int r);
        if (r == 0) return 0;
        if (r == 1) return 1;
        if (r == 2) return (NB == 8) ? 3 : 2;
        return (NB == 8) ? 4 : 3;
    endfunction

    logic [0:W-1]       shifted;
    logic [0:W-1]       mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               init_done_q;
    logic               push, pop;

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        shifted = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NB; c++) begin
                if (in_inv)
                    shifted[8*(r*NB + c) +: 8] =
                        in_state[8*(r*NB + ((c - row_off(r) + NB) % NB)) +: 8];
                else
                    shifted[8*(r*NB + c) +: 8] =
                        in_state[8*(r*NB + ((c + row_off(r)) % NB)) +: 8];
            end
        end
    end

    // in_ready depends only on registers, never combinationally on out_ready.
    assign in_ready  = init_done_q && (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_state = mem_q[rd_ptr_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            init_done_q <= 1'b1;
        end
    end

    // NOTE: the storage is reset on purpose so out_state reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= shifted;
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe: NB=4 and NB=8 instances checked
// against a row-rotation reference model.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready;
    logic [0:127] a_in_state, a_out_state;
    logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
    logic [0:255] b_in_state, b_out_state;

    shift_rows_pipe #(.NB(4), .DEPTH(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_state(a_in_state), .in_inv(a_in_inv),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_state(a_out_state)
    );

    shift_rows_pipe #(.NB(8), .DEPTH(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_state(b_in_state), .in_inv(b_in_inv),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_state(b_out_state)
    );

    // Reference: each row is a queue of bytes rotated left (forward) or right (inverse).
    function automatic logic [0:255] ref_shift(input logic [0:255] s, input int nb, input bit inv);
        logic [0:255] res;
        logic [7:0]   row[$];
        int           off;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            row = {};
            for (int c = 0; c < nb; c++) row.push_back(s[8*(r*nb + c) +: 8]);
            if (r == 0)      off = 0;
            else if (r == 1) off = 1;
            else if (r == 2) off = (nb == 8) ? 3 : 2;
            else             off = (nb == 8) ? 4 : 3;
            repeat (off) begin
                if (inv) row.push_front(row.pop_back());
                else     row.push_back(row.pop_front());
            end
            for (int c = 0; c < nb; c++) res[8*(r*nb + c) +: 8] = row[c];
        end
        return res;
    endfunction

    function automatic logic [0:127] ref4(input logic [0:127] s, input bit inv);
        logic [0:255] t;
        t = ref_shift({s, 128'h0}, 4, inv);
        return t[0:127];
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        #2;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got=%b exp=0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state got=%h exp=0", a_out_state); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid8 got=%b exp=0", b_out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high got=%b exp=1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_after got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_forward_inverse4();
        logic [0:127] inp, fwd;
        inp = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_state = inp; a_in_inv = 1'b0;
        @(negedge clk);
        a_in_inv = 1'b1;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL fwd4_valid got=%b exp=1", a_out_valid); end
        checks++; if (a_out_state !== 128'h00010203_05060704_0A0B0809_0F0C0D0E) begin
            errors++; $display("FAIL fwd4_state got=%h exp=00010203050607040a0b08090f0c0d0e", a_out_state); end
        fwd = a_out_state;
        @(negedge clk);
        checks++; if (a_out_state !== 128'h00010203_07040506_0A0B0809_0D0E0F0C) begin
            errors++; $display("FAIL inv4_state got=%h exp=00010203070405060a0b08090d0e0f0c", a_out_state); end
        a_in_state = 128'h00010203_05060704_0A0B0809_0F0C0D0E;
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++; if (a_out_state !== inp) begin errors++; $display("FAIL inv4_roundtrip got=%h exp=%h", a_out_state, inp); end
        checks++; if (fwd !== ref4(inp, 1'b0)) begin errors++; $display("FAIL fwd4_model got=%h exp=%h", fwd, ref4(inp, 1'b0)); end
        @(negedge clk);
    endtask

    task automatic test_nb8();
        logic [0:255] inp, exp_q[$];
        for (int k = 0; k < 32; k++) inp[8*k +: 8] = 8'(k);
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_state = inp; b_in_inv = 1'b0;
        @(negedge clk);
        b_in_valid = 1'b0;
        checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL nb8_valid got=%b exp=1", b_out_valid); end
        checks++; if (b_out_state[0:63] !== 64'h00010203_04050607) begin
            errors++; $display("FAIL nb8_row0 got=%h exp=0001020304050607", b_out_state[0:63]); end
        checks++; if (b_out_state[64:127] !== 64'h090A0B0C_0D0E0F08) begin
            errors++; $display("FAIL nb8_row1 got=%h exp=090a0b0c0d0e0f08", b_out_state[64:127]); end
        checks++; if (b_out_state[128:191] !== 64'h13141516_17101112) begin
            errors++; $display("FAIL nb8_row2 got=%h exp=1314151617101112", b_out_state[128:191]); end
        checks++; if (b_out_state[192:255] !== 64'h1C1D1E1F_18191A1B) begin
            errors++; $display("FAIL nb8_row3 got=%h exp=1c1d1e1f18191a1b", b_out_state[192:255]); end
        // Random back-to-back beats with random modes; each appears one cycle later.
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                b_in_valid = 1'b1;
                b_in_state = {rand128(), rand128()};
                b_in_inv   = 1'($urandom_range(1));
                exp_q.push_back(ref_shift(b_in_state, 8, b_in_inv));
            end else begin
                b_in_valid = 1'b0;
            end
            if (i > 0) begin
                checks++; if (b_out_valid !== 1'b1 || b_out_state !== exp_q[0]) begin
                    errors++; $display("FAIL nb8_rand[%0d] got=%b/%h exp=1/%h", i - 1, b_out_valid, b_out_state, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [0:127] sa, sb, sc;
        sa = rand128(); sb = rand128(); sc = rand128();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_state = sa; a_in_inv = 1'b0;
        @(negedge clk);
        a_in_state = sb; a_in_inv = 1'b1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a got=%b exp=1", a_in_ready); end
        @(negedge clk);
        a_in_state = sc; a_in_inv = 1'b0;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_b got=%b exp=0", a_in_ready); end
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_hold got=%b exp=0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b1 || a_out_state !== ref4(sa, 1'b0)) begin
            errors++; $display("FAIL bp_hold_a got=%b/%h exp=1/%h", a_out_valid, a_out_state, ref4(sa, 1'b0)); end
        a_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_reassert got=%b exp=1", a_in_ready); end
        checks++; if (a_out_state !== ref4(sb, 1'b1)) begin errors++; $display("FAIL bp_out_b got=%h exp=%h", a_out_state, ref4(sb, 1'b1)); end
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1 || a_out_state !== ref4(sc, 1'b0)) begin
            errors++; $display("FAIL bp_out_c got=%b/%h exp=1/%h", a_out_valid, a_out_state, ref4(sc, 1'b0)); end
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_streaming();
        logic [0:127] q[$];
        logic [0:127] cur_s;
        bit           cur_inv, pending;
        int           sent, rcvd, cyc;
        sent = 0; rcvd = 0; cyc = 0; pending = 1'b0; cur_s = '0; cur_inv = 1'b0;
        while ((sent < 100 || rcvd < 100) && cyc < 3000) begin
            cyc++;
            checks++; if (a_out_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL stream_out_valid cyc=%0d got=%b exp=%0b", cyc, a_out_valid, q.size() != 0); end
            checks++; if (a_in_ready !== (q.size() < 2)) begin
                errors++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=%0b", cyc, a_in_ready, q.size() < 2); end
            if (!pending && sent < 100 && $urandom_range(1) == 1) begin
                cur_s = rand128(); cur_inv = 1'($urandom_range(1)); pending = 1'b1;
            end
            a_in_valid = pending; a_in_state = cur_s; a_in_inv = cur_inv;
            a_out_ready = 1'($urandom_range(1));
            if (a_out_valid === 1'b1 && a_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stream_extra_beat got=%h exp=none", a_out_state);
                end else begin
                    if (a_out_state !== q[0]) begin
                        errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", rcvd, a_out_state, q[0]); end
                    void'(q.pop_front());
                end
                rcvd++;
            end
            if (pending && a_in_ready === 1'b1) begin
                q.push_back(ref4(cur_s, cur_inv));
                pending = 1'b0;
                sent++;
            end
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        checks++; if (rcvd != 100 || sent != 100) begin
            errors++; $display("FAIL stream_count got=%0d/%0d exp=100/100", sent, rcvd); end
    endtask

    task automatic test_back_to_back();
        logic [0:127] exp_q[$];
        a_out_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, a_in_ready); end
                a_in_valid = 1'b1; a_in_state = rand128(); a_in_inv = 1'(i % 2);
                exp_q.push_back(ref4(a_in_state, a_in_inv));
            end else begin
                a_in_valid = 1'b0;
            end
            if (i > 0) begin
                checks++; if (a_out_valid !== 1'b1 || a_out_state !== exp_q[0]) begin
                    errors++; $display("FAIL b2b_out[%0d] got=%b/%h exp=1/%h", i - 1, a_out_valid, a_out_state, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_state = rand128(); a_in_inv = 1'b0;
        @(negedge clk);
        a_in_state = rand128(); a_in_inv = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_full got=%b/%b exp=1/0", a_out_valid, a_in_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_out_state !== 128'h0) begin errors++; $display("FAIL rstmid_out_state got=%h exp=0", a_out_state); end
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d] got=%b exp=0", i, a_out_valid); end
        end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", a_in_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_state = '0; a_in_inv = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_state = '0; b_in_inv = 1'b0; b_out_ready = 1'b1;
        test_reset();
        test_forward_inverse4();
        test_nb8();
        test_backpressure();
        test_streaming();
        @(negedge clk);
        a_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
